// File: rtl/amiga_trigger_rx_pkg.sv
// Shared constants, FSM encoding and codeword field helpers for the AMIGA LTS link receiver.
package amiga_trigger_rx_pkg;

  localparam int LTS_LEN      = 16;
  localparam int HAMM_ENC_LEN = 22;
  localparam int SYN_W        = 5;
  localparam int CW_PAR_IDX   = HAMM_ENC_LEN - 1;  // overall even-parity bit, sent first

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } rx_state_e;

  // Data bits occupy every non-power-of-two Hamming position (position = index + 1).
  function automatic logic [LTS_LEN-1:0] extract_data(input logic [HAMM_ENC_LEN-1:0] cw);
    return {cw[20:16], cw[14:8], cw[6:4], cw[2]};
  endfunction

endpackage

// File: rtl/amiga_trigger_rx_dec.sv
// Combinational SECDED decoder for the 22-bit LTS codeword: corrects one error, flags two.
module hamming_secded_dec22
  import amiga_trigger_rx_pkg::*;
(
  input  logic [HAMM_ENC_LEN-1:0] cw_i,
  output logic [LTS_LEN-1:0]      data_o,
  output logic                    corrected_o,
  output logic                    uncorrectable_o
);

  logic [SYN_W-1:0]        syn;
  logic                    par;
  logic [HAMM_ENC_LEN-1:0] fixed;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves it unassigned (no latch).
    syn             = '0;
    par             = ^cw_i;
    fixed           = cw_i;
    corrected_o     = 1'b0;
    uncorrectable_o = 1'b0;

    for (int i = 0; i < CW_PAR_IDX; i++) begin
      if (cw_i[i]) syn = syn ^ SYN_W'(i + 1);
    end

    if (syn == '0) begin
      corrected_o = par;  // only the overall parity bit itself was hit
    end else if (par) begin
      if (syn <= SYN_W'(CW_PAR_IDX)) begin
        fixed[syn - 5'd1] = ~fixed[syn - 5'd1];
        corrected_o       = 1'b1;
      end else begin
        uncorrectable_o = 1'b1;  // odd error count pointing outside the word
      end
    end else begin
      uncorrectable_o = 1'b1;
    end

    data_o = extract_data(fixed);
  end

endmodule

// File: rtl/amiga_trigger_rx.sv
// AMIGA LTS link receiver: synchronises ser_clk/ser_data, deserialises 22-bit frames,
// decodes them through a two-stage pipeline and keeps saturating error counters.
module amiga_trigger_rx
  import amiga_trigger_rx_pkg::*;
#(
  parameter int DENOMINATOR  = 12,
  parameter int SYNC_STAGES  = 2,
  parameter int IDLE_TIMEOUT = 4 * DENOMINATOR
) (
  input  logic               clock_120M,
  input  logic               resetn,
  input  logic               ser_clk,
  input  logic               ser_data,
  input  logic               cnt_clear,
  output logic [LTS_LEN-1:0] lts_out,
  output logic               lts_valid,
  output logic               corrected,
  output logic               uncorrectable,
  output logic               frame_err,
  output logic               busy,
  output logic [15:0]        cnt_corrected,
  output logic [15:0]        cnt_uncorr
);

  localparam int                  TIMER_W      = $clog2(IDLE_TIMEOUT);
  localparam logic [TIMER_W-1:0]  TIMEOUT_LAST = TIMER_W'(IDLE_TIMEOUT - 1);
  localparam logic [4:0]          LAST_BIT     = 5'(HAMM_ENC_LEN - 1);

  logic [SYNC_STAGES-1:0]  sclk_sync_q, sdat_sync_q;
  logic                    sclk_d_q;
  logic                    sclk_s, sdat_s, rise;

  rx_state_e               state_q, state_d;
  logic [HAMM_ENC_LEN-2:0] shift_q, shift_d;
  logic [4:0]              bit_cnt_q, bit_cnt_d;
  logic [TIMER_W-1:0]      timer_q, timer_d;
  logic [HAMM_ENC_LEN-1:0] cw_q, cw_d;
  logic                    dec_go_q, dec_go_d;
  logic                    frame_err_q, frame_err_d;

  logic [LTS_LEN-1:0]      dec_data;
  logic                    dec_corr, dec_unc;
  logic [LTS_LEN-1:0]      dec_data_q, lts_out_q;
  logic                    dec_vld_q, dec_corr_q, dec_unc_q;
  logic                    lts_valid_q, corr_q, unc_q;
  logic [15:0]             cnt_corr_q, cnt_unc_q;

  // Clock and data share the same depth so the sampled bit lines up with the detected rise.
  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign sdat_s = sdat_sync_q[SYNC_STAGES-1];
  assign rise   = sclk_s & ~sclk_d_q;

  always_ff @(posedge clock_120M or negedge resetn) begin
    if (!resetn) begin
      sclk_sync_q <= '0;
      sdat_sync_q <= '0;
      sclk_d_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample pre-edge values, forming a true shift chain.
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], ser_clk};
      sdat_sync_q <= {sdat_sync_q[SYNC_STAGES-2:0], ser_data};
      sclk_d_q    <= sclk_s;
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    timer_d     = timer_q;
    cw_d        = cw_q;
    dec_go_d    = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (rise) begin
          shift_d   = {shift_q[HAMM_ENC_LEN-3:0], sdat_s};
          bit_cnt_d = 5'd1;
          timer_d   = '0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (rise) begin
          shift_d = {shift_q[HAMM_ENC_LEN-3:0], sdat_s};
          timer_d = '0;
          if (bit_cnt_q == LAST_BIT) begin
            cw_d      = {shift_q, sdat_s};
            dec_go_d  = 1'b1;
            bit_cnt_d = '0;
            state_d   = ST_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end else if (timer_q == TIMEOUT_LAST) begin
          frame_err_d = 1'b1;
          bit_cnt_d   = '0;
          timer_d     = '0;
          state_d     = ST_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_120M or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      timer_q     <= '0;
      cw_q        <= '0;
      dec_go_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      timer_q     <= timer_d;
      cw_q        <= cw_d;
      dec_go_q    <= dec_go_d;
      frame_err_q <= frame_err_d;
    end
  end

  hamming_secded_dec22 u_dec (
    .cw_i           (cw_q),
    .data_o         (dec_data),
    .corrected_o    (dec_corr),
    .uncorrectable_o(dec_unc)
  );

  // Stage 1 captures the decoder result; stage 2 publishes it and updates the counters.
  always_ff @(posedge clock_120M or negedge resetn) begin
    if (!resetn) begin
      dec_vld_q   <= 1'b0;
      dec_data_q  <= '0;
      dec_corr_q  <= 1'b0;
      dec_unc_q   <= 1'b0;
      lts_valid_q <= 1'b0;
      lts_out_q   <= '0;
      corr_q      <= 1'b0;
      unc_q       <= 1'b0;
      cnt_corr_q  <= '0;
      cnt_unc_q   <= '0;
    end else begin
      dec_vld_q   <= dec_go_q;
      dec_data_q  <= dec_data;
      dec_corr_q  <= dec_corr;
      dec_unc_q   <= dec_unc;
      lts_valid_q <= dec_vld_q;
      if (dec_vld_q) begin
        lts_out_q <= dec_data_q;
        corr_q    <= dec_corr_q;
        unc_q     <= dec_unc_q;
      end

      if (cnt_clear) begin
        cnt_corr_q <= '0;
        cnt_unc_q  <= '0;
      end else if (dec_vld_q) begin
        if (dec_corr_q && cnt_corr_q != 16'hFFFF) cnt_corr_q <= cnt_corr_q + 16'd1;
        if (dec_unc_q  && cnt_unc_q  != 16'hFFFF) cnt_unc_q  <= cnt_unc_q  + 16'd1;
      end
    end
  end

  assign lts_out       = lts_out_q;
  assign lts_valid     = lts_valid_q;
  assign corrected     = corr_q;
  assign uncorrectable = unc_q;
  assign frame_err     = frame_err_q;
  assign busy          = (state_q != ST_IDLE);
  assign cnt_corrected = cnt_corr_q;
  assign cnt_uncorr    = cnt_unc_q;

endmodule

// File: tb/tb_amiga_trigger_rx.sv
// Directed bench for amiga_trigger_rx: emulates the serial transmitter and checks decoded frames.
module tb_amiga_trigger_rx;

  localparam int HALF = 6;  // ser_clk half period in clock_120M cycles

  logic        clock_120M = 1'b0;
  logic        resetn     = 1'b0;
  logic        ser_clk    = 1'b0;
  logic        ser_data   = 1'b0;
  logic        cnt_clear  = 1'b0;
  logic [15:0] lts_out;
  logic        lts_valid, corrected, uncorrectable, frame_err, busy;
  logic [15:0] cnt_corrected, cnt_uncorr;

  int          n_tests  = 0;
  int          n_fail   = 0;
  int          ferr_cnt = 0;
  logic [17:0] vq[$];  // {uncorrectable, corrected, lts_out} per lts_valid cycle

  amiga_trigger_rx dut (
    .clock_120M   (clock_120M),
    .resetn       (resetn),
    .ser_clk      (ser_clk),
    .ser_data     (ser_data),
    .cnt_clear    (cnt_clear),
    .lts_out      (lts_out),
    .lts_valid    (lts_valid),
    .corrected    (corrected),
    .uncorrectable(uncorrectable),
    .frame_err    (frame_err),
    .busy         (busy),
    .cnt_corrected(cnt_corrected),
    .cnt_uncorr   (cnt_uncorr)
  );

  always #4 clock_120M = ~clock_120M;

  always @(negedge clock_120M) begin
    if (lts_valid) vq.push_back({uncorrectable, corrected, lts_out});
    if (frame_err) ferr_cnt++;
  end

  // Textbook Hamming(21,16) encoder plus overall even parity in bit 21.
  function automatic logic [21:0] encode(input logic [15:0] d);
    logic [21:0] cw;
    int          k;
    cw = '0;
    k  = 0;
    for (int pos = 1; pos <= 21; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        cw[pos-1] = d[k];
        k++;
      end
    end
    for (int b = 0; b < 5; b++) begin
      logic p;
      p = 1'b0;
      for (int pos = 1; pos <= 21; pos++) begin
        if (((pos >> b) & 1) == 1) p = p ^ cw[pos-1];
      end
      cw[(1 << b) - 1] = p;
    end
    cw[21] = ^cw[20:0];
    return cw;
  endfunction

  task automatic send_bits(input logic [21:0] cw, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ser_clk  = 1'b0;
      ser_data = cw[21-i];
      repeat (HALF) @(negedge clock_120M);
      ser_clk = 1'b1;
      repeat (HALF) @(negedge clock_120M);
    end
    ser_clk = 1'b0;
  endtask

  task automatic wait_frame(output bit got, output logic [17:0] rec);
    for (int c = 0; c < 60 && vq.size() == 0; c++) @(negedge clock_120M);
    got = (vq.size() != 0);
    rec = got ? vq.pop_front() : 18'h0;
  endtask

  task automatic test_frame(input string name, input logic [15:0] d, input logic [21:0] flip,
                            input logic [17:0] exp);
    bit          got;
    logic [17:0] rec;
    send_bits(encode(d) ^ flip, 22);
    wait_frame(got, rec);
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s: no lts_valid within bound, required one strobe", name);
    end else begin
      n_tests++;
      if (rec !== exp) begin
        n_fail++;
        $display("FAIL %s: got unc/corr/data=%h required %h", name, rec, exp);
      end
    end
    repeat (12) @(negedge clock_120M);
    n_tests++;
    if (vq.size() != 0) begin
      n_fail++;
      $display("FAIL %s_single_strobe: %0d extra strobes, required 0", name, vq.size());
      vq.delete();
    end
  endtask

  task automatic test_reset();
    repeat (5) @(negedge clock_120M);
    n_tests++;
    if (lts_out !== 16'h0) begin
      n_fail++; $display("FAIL reset_lts_out: got %h required 0000", lts_out);
    end
    n_tests++;
    if ({lts_valid, corrected, uncorrectable, frame_err, busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required 00000",
               {lts_valid, corrected, uncorrectable, frame_err, busy});
    end
    n_tests++;
    if ({cnt_corrected, cnt_uncorr} !== 32'h0) begin
      n_fail++; $display("FAIL reset_counters: got %h/%h required 0/0", cnt_corrected, cnt_uncorr);
    end
    resetn = 1'b1;
    repeat (5) @(negedge clock_120M);
  endtask

  task automatic test_loopback();
    test_frame("loopback_1234", 16'h1234, 22'h0, {2'b00, 16'h1234});
  endtask

  task automatic test_patterns();
    n_tests++;
    if (encode(16'h0000) !== 22'h0) begin
      n_fail++; $display("FAIL encode_zero: got %h required 000000", encode(16'h0000));
    end
    test_frame("pattern_0000", 16'h0000, 22'h0, {2'b00, 16'h0000});
    test_frame("pattern_ffff", 16'hFFFF, 22'h0, {2'b00, 16'hFFFF});
  endtask

  task automatic test_single_error();
    test_frame("flip_cw9", 16'hA5C3, 22'h1 << 9, {2'b01, 16'hA5C3});
    n_tests++;
    if (cnt_corrected !== 16'd1) begin
      n_fail++; $display("FAIL cnt_corrected_1: got %0d required 1", cnt_corrected);
    end
    test_frame("flip_cw21", 16'hA5C3, 22'h1 << 21, {2'b01, 16'hA5C3});
    n_tests++;
    if (cnt_corrected !== 16'd2) begin
      n_fail++; $display("FAIL cnt_corrected_2: got %0d required 2", cnt_corrected);
    end
  endtask

  task automatic test_double_error();
    // d0 (cw[2]) and d5 (cw[9]) flipped: raw data 0xA5C3 ^ 0x0021 = 0xA5E2.
    test_frame("flip_cw2_cw9", 16'hA5C3, (22'h1 << 2) | (22'h1 << 9), {2'b10, 16'hA5E2});
    n_tests++;
    if ({uncorrectable, corrected, cnt_uncorr} !== {2'b10, 16'd1}) begin
      n_fail++;
      $display("FAIL double_hold: got unc=%b corr=%b cnt=%0d required 1 0 1",
               uncorrectable, corrected, cnt_uncorr);
    end
    // Positions 16,4,2 flipped: syndrome 22 with odd parity, outside the word.
    test_frame("syndrome_22", 16'hA5C3, (22'h1 << 15) | (22'h1 << 3) | (22'h1 << 1),
               {2'b10, 16'hA5C3});
    n_tests++;
    if (cnt_uncorr !== 16'd2) begin
      n_fail++; $display("FAIL cnt_uncorr_2: got %0d required 2", cnt_uncorr);
    end
  endtask

  task automatic test_timeout();
    int ferr0;
    ferr0 = ferr_cnt;
    send_bits(encode(16'hBEEF), 10);
    repeat (60) @(negedge clock_120M);
    n_tests++;
    if (ferr_cnt != ferr0 + 1) begin
      n_fail++; $display("FAIL timeout_frame_err: got %0d pulses required 1", ferr_cnt - ferr0);
    end
    n_tests++;
    if (vq.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_no_valid: got %0d strobes busy=%b required 0 0", vq.size(), busy);
      vq.delete();
    end
    test_frame("after_timeout", 16'h0F0F, 22'h0, {2'b00, 16'h0F0F});
  endtask

  task automatic test_mid_reset();
    int ferr0;
    send_bits(encode(16'h1234), 15);
    resetn = 1'b0;
    repeat (3) @(negedge clock_120M);
    n_tests++;
    if ({lts_out, corrected, uncorrectable, busy, cnt_corrected, cnt_uncorr} !== 51'h0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got lts=%h c=%b u=%b busy=%b cnt=%0d/%0d required all 0",
               lts_out, corrected, uncorrectable, busy, cnt_corrected, cnt_uncorr);
    end
    resetn = 1'b1;
    ferr0  = ferr_cnt;
    repeat (80) @(negedge clock_120M);
    n_tests++;
    if (vq.size() != 0 || ferr_cnt != ferr0) begin
      n_fail++;
      $display("FAIL midreset_no_strobes: got %0d valid %0d ferr required 0 0",
               vq.size(), ferr_cnt - ferr0);
      vq.delete();
    end
    test_frame("after_reset_00ff", 16'h00FF, 22'h0, {2'b00, 16'h00FF});
  endtask

  task automatic test_counter_clear();
    test_frame("flip_p1", 16'h3C3C, 22'h1, {2'b01, 16'h3C3C});
    n_tests++;
    if (cnt_corrected !== 16'd1) begin
      n_fail++; $display("FAIL cnt_before_clear: got %0d required 1", cnt_corrected);
    end
    cnt_clear = 1'b1;
    @(negedge clock_120M);
    cnt_clear = 1'b0;
    n_tests++;
    if ({cnt_corrected, cnt_uncorr} !== 32'h0) begin
      n_fail++; $display("FAIL cnt_clear: got %0d/%0d required 0/0", cnt_corrected, cnt_uncorr);
    end
  endtask

  task automatic test_back_to_back();
    bit          got;
    logic [17:0] rec;
    send_bits(encode(16'h5555) ^ (22'h1 << 13), 22);
    send_bits(encode(16'h8001), 22);
    wait_frame(got, rec);
    n_tests++;
    if (!got || rec !== {2'b01, 16'h5555}) begin
      n_fail++; $display("FAIL b2b_first: got=%b rec=%h required %h", got, rec, {2'b01, 16'h5555});
    end
    wait_frame(got, rec);
    n_tests++;
    if (!got || rec !== {2'b00, 16'h8001}) begin
      n_fail++; $display("FAIL b2b_second: got=%b rec=%h required %h", got, rec, {2'b00, 16'h8001});
    end
    n_tests++;
    if (cnt_corrected !== 16'd1) begin
      n_fail++; $display("FAIL b2b_cnt: got %0d required 1", cnt_corrected);
    end
  endtask

  initial begin
    repeat (50000) @(posedge clock_120M);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_loopback();
    test_patterns();
    test_single_error();
    test_double_error();
    test_timeout();
    test_mid_reset();
    test_counter_clear();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
